// File: rtl/p2s_tx_scheduler.sv
// -----------------------------------------------------------------------------
// p2s_tx_scheduler
//   Shares one serial output lane between NUM_REQ parallel requesters. An
//   IDLE cycle grants the round-robin winner over a valid/ready handshake.
//   SHIFT then sends the accepted word MSB-first, one bit per cycle, and GAP
//   holds the lane idle for GAP_CYCLES cycles before the next grant.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-high reset
//   req_valid  in   [NUM_REQ]             per-requester word valid
//   req_data   in   [NUM_REQ*DATA_WIDTH]  requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  out  [NUM_REQ]             one-hot (or zero) accept, IDLE only
//   sdata      out  serial data, MSB first
//   svalid     out  high while sdata carries a data bit
//   sid        out  [SID_W] requester owning the word on sdata, 0 when idle
//   busy       out  high in SHIFT and GAP
// -----------------------------------------------------------------------------
module p2s_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 1,
    localparam int SID_W     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          sdata,
    output logic                          svalid,
    output logic [SID_W-1:0]              sid,
    output logic                          busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam int GAP_W = 4;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 16 || DATA_WIDTH < 2 || DATA_WIDTH > 32 ||
            GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_params
            $error("p2s_tx_scheduler: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [GAP_W-1:0]        r_gap_cnt;
    logic [SID_W-1:0]        r_sid;
    logic [SID_W-1:0]        r_last_grant;

    logic                    w_found;
    logic [SID_W-1:0]        w_grant;
    logic [SID_W-1:0]        w_idx;
    logic                    w_load;

    // Round-robin search starting just after the previous winner, so the
    // last-served requester has the lowest priority on the next grant.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = SID_W'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        w_load    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The grant is suppressed while reset is held even though the
                // state register already reads IDLE.
                if (w_found && !rst) begin
                    req_ready[w_grant] = 1'b1;
                    w_load             = 1'b1;
                    w_next             = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_bit_cnt == '0) begin
                    w_next = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_sid        <= '0;
            r_last_grant <= SID_W'(NUM_REQ - 1);
        end else begin
            // NOTE: state flops use non-blocking assignments so every flop in
            // the design samples pre-edge values regardless of block order.
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_shift      <= req_data[w_grant*DATA_WIDTH +: DATA_WIDTH];
                        r_sid        <= w_grant;
                        r_last_grant <= w_grant;
                        r_bit_cnt    <= CNT_W'(DATA_WIDTH - 1);
                    end
                end
                S_SHIFT: begin
                    r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
                    if (r_bit_cnt != '0) begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end else if (GAP_CYCLES > 0) begin
                        r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt != '0) begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode only flop contents, never req_*.
    assign svalid = (r_state == S_SHIFT);
    assign sdata  = (r_state == S_SHIFT) ? r_shift[DATA_WIDTH-1] : 1'b0;
    assign sid    = (r_state == S_SHIFT) ? r_sid : '0;
    assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_p2s_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_p2s_tx_scheduler
//   Directed bench for p2s_tx_scheduler. Instance a_dut uses the default
//   parameters; z_dut uses GAP_CYCLES=0. Inputs are driven and outputs
//   sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_p2s_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic [3:0]  a_valid, a_ready, z_valid, z_ready;
    logic [31:0] a_data, z_data;
    logic        a_sdata, a_svalid, a_busy, z_sdata, z_svalid, z_busy;
    logic [1:0]  a_sid, z_sid;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    p2s_tx_scheduler a_dut (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_data(a_data),
        .req_ready(a_ready), .sdata(a_sdata), .svalid(a_svalid),
        .sid(a_sid), .busy(a_busy)
    );

    p2s_tx_scheduler #(.GAP_CYCLES(0)) z_dut (
        .clk(clk), .rst(rst), .req_valid(z_valid), .req_data(z_data),
        .req_ready(z_ready), .sdata(z_sdata), .svalid(z_svalid),
        .sid(z_sid), .busy(z_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {svalid, sdata, sid, busy, req_ready}
    function automatic logic [8:0] obs(input bit z);
        return z ? {z_svalid, z_sdata, z_sid, z_busy, z_ready}
                 : {a_svalid, a_sdata, a_sid, a_busy, a_ready};
    endfunction

    // Called in the MSB cycle; returns at the falling edge after the LSB.
    task automatic serial(input bit z, input logic [7:0] w, input logic [1:0] id, input string tag);
        for (int i = 7; i >= 0; i--) begin
            #1;
            check(tag, 32'(obs(z)), 32'({1'b1, w[i], id, 1'b1, 4'b0000}));
            @(negedge clk);
        end
    endtask

    task automatic wait_grant(input bit z, input int budget, output logic [3:0] g);
        g = '0;
        for (int n = 0; n < budget; n++) begin
            #1;
            g = z ? z_ready : a_ready;
            if (g != '0) return;
            @(negedge clk);
        end
        check("grant_timeout", 32'(g), 32'h1);
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst = 1'b1;
        a_valid = '0;
        z_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [3:0] g;
        int         prev;
        int         id;

        rst = 1'b1;
        a_valid = '0; z_valid = '0;
        a_data = '0;  z_data = '0;

        // Reset and idle.
        repeat (3) begin
            @(negedge clk);
            check("rst_a", 32'(obs(0)), 32'h0);
            check("rst_z", 32'(obs(1)), 32'h0);
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("idle_a", 32'(obs(0)), 32'h0);
        end

        // Single word from requester 2.
        a_data[2*8 +: 8] = 8'hA5;
        a_valid = 4'b0100;
        wait_grant(0, 5, g);
        check("single_grant", 32'(g), 32'h4);
        @(negedge clk);
        a_valid = '0;
        serial(0, 8'hA5, 2'd2, "single_bit");
        #1 check("single_gap", 32'(obs(0)), 32'(9'b0_0_00_1_0000));
        @(negedge clk);
        #1 check("single_idle", 32'(obs(0)), 32'h0);

        // Round robin with all requesters valid.
        reset_all();
        for (int i = 0; i < 4; i++) a_data[i*8 +: 8] = 8'(8'h11 * (i + 1));
        a_valid = 4'hF;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            id = k % 4;
            wait_grant(0, 30, g);
            check("rr_grant", 32'(g), 32'(4'b0001 << id));
            if (k > 0) check("rr_period", 32'(cyc - prev), 32'd10);
            prev = cyc;
            @(negedge clk);
            serial(0, 8'(8'h11 * (id + 1)), 2'(id), "rr_bit");
        end
        a_valid = '0;

        // Zero gap: requesters 1 and 3 alternate with a 9-cycle period.
        reset_all();
        z_data[1*8 +: 8] = 8'h81;
        z_data[3*8 +: 8] = 8'h3C;
        z_valid = 4'b1010;
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            id = (k % 2 == 1) ? 3 : 1;
            wait_grant(1, 30, g);
            check("zg_grant", 32'(g), 32'(4'b0001 << id));
            if (k > 0) begin
                check("zg_period", 32'(cyc - prev), 32'd9);
                check("zg_idle", 32'(obs(1)), 32'({5'b0, 4'b0001 << id}));
            end
            prev = cyc;
            @(negedge clk);
            serial(1, (id == 3) ? 8'h3C : 8'h81, 2'(id), "zg_bit");
        end
        z_valid = '0;

        // Late requester 0 raises valid in the third SHIFT cycle of requester 1.
        reset_all();
        a_data[1*8 +: 8] = 8'h0F;
        a_data[0*8 +: 8] = 8'hF0;
        a_valid = 4'b0010;
        wait_grant(0, 5, g);
        check("late_grant1", 32'(g), 32'h2);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) a_valid[0] = 1'b1;
            #1 check("late_shift", 32'(obs(0)), 32'({1'b1, 1'(8'h0F >> (7 - i)), 2'd1, 1'b1, 4'b0000}));
            @(negedge clk);
        end
        #1 check("late_gap", 32'(obs(0)), 32'(9'b0_0_00_1_0000));
        @(negedge clk);
        wait_grant(0, 5, g);
        check("late_grant0", 32'(g), 32'h1);
        @(negedge clk);
        a_valid = '0;
        serial(0, 8'hF0, 2'd0, "late_bit");

        // Reset during bit 4 of 0xFF from requester 3.
        a_data[3*8 +: 8] = 8'hFF;
        a_valid = 4'b1000;
        wait_grant(0, 5, g);
        check("mid_grant3", 32'(g), 32'h8);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 check("mid_bit", 32'(obs(0)), 32'({1'b1, 1'b1, 2'd3, 1'b1, 4'b0000}));
            if (i < 3) @(negedge clk);
        end
        rst = 1'b1;
        a_data[0*8 +: 8] = 8'h5A;
        a_valid = 4'b1001;
        #1 check("mid_async", 32'(obs(0)), 32'h0);
        @(negedge clk);
        #1 check("mid_held", 32'(obs(0)), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_grant(0, 5, g);
        check("mid_grant0", 32'(g), 32'h1);
        @(negedge clk);
        a_valid = '0;
        serial(0, 8'h5A, 2'd0, "mid_after_bit");
        #1 check("mid_gap", 32'(obs(0)), 32'(9'b0_0_00_1_0000));
        @(negedge clk);
        #1 check("mid_idle", 32'(obs(0)), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/p2s_tx_scheduler.md
Name: p2s_tx_scheduler

Overview:
Round-robin scheduler and serializer controller that shares one parallel-to-serial output lane between NUM_REQ parallel requesters. It accepts one word at a time over a valid/ready handshake, shifts it out MSB-first on sdata with a qualifying svalid, and inserts a programmable idle gap between words. It sits directly in front of the serial output interface (clk, sdata) and is the only driver of sdata.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16.
DATA_WIDTH, 8, parallel word width in bits; legal range 2..32.
GAP_CYCLES, 1, idle cycles forced after each word's last bit; legal range 0..15.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  reset.
req_valid  input  NUM_REQ  per-requester word-valid.
req_data  input  NUM_REQ*DATA_WIDTH  requester i's word is slice [i*DATA_WIDTH +: DATA_WIDTH].
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
sdata  output  1  serial data, MSB first.
svalid  output  1  high on every cycle that sdata carries a data bit.
sid  output  max(1,$clog2(NUM_REQ))  index of the requester whose word is on sdata; 0 when svalid=0.
busy  output  1  high in SHIFT and GAP.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- While rst=1: state=IDLE, sdata=0, svalid=0, sid=0, busy=0, req_ready=0, bit counter=0, gap counter=0, last_grant=NUM_REQ-1. Reset asserted mid-word aborts the word immediately; the word is not resumed after reset.
- States: IDLE, SHIFT, GAP.
- IDLE: req_ready is combinational. It is asserted only for the winner g, which is the first index with req_valid=1 searching last_grant+1, last_grant+2, ... modulo NUM_REQ. If no req_valid is high, req_ready=0 and the state stays IDLE. req_ready is never asserted outside IDLE.
- Transfer: occurs when req_valid[g] & req_ready[g] at a rising edge. On that edge, req_data slice g loads into the shift register, sid_reg<=g, last_grant<=g, bit counter<=DATA_WIDTH-1, and the state goes to SHIFT.
- SHIFT: svalid=1, sdata=shift register MSB, sid=sid_reg, busy=1. Each cycle the register shifts left and the counter decrements. When the counter is 0 (the last bit is on sdata), the next state is GAP if GAP_CYCLES>0, otherwise IDLE.
- GAP: svalid=0, sdata=0, sid=0, busy=1 for exactly GAP_CYCLES cycles, then IDLE.
- sdata, svalid, sid and busy are registered and driven by state/datapath flops, with no combinational path from req_*.
- Latency: a transfer at edge T gives the MSB at cycle T+1 and the LSB at cycle T+DATA_WIDTH. The earliest next transfer edge is T+DATA_WIDTH+GAP_CYCLES+1, so a continuous stream has a period of DATA_WIDTH+GAP_CYCLES+1 cycles.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0,... A requester that drops valid is skipped without penalty to the others.
- Requester-side rules: req_data and req_valid may change freely while req_ready=0. After the transfer edge, changes have no effect on the word in flight.
- Simultaneous events: when several requesters assert valid in the same IDLE cycle, only the round-robin winner is granted. A requester that raises valid during SHIFT/GAP waits for IDLE.
- X/illegal: req_valid bits for indices >= NUM_REQ do not exist. Out-of-range parameters are rejected by an elaboration-time check.

Test Plan:
- Reset/idle: hold rst=1 for 3 cycles, then release with all req_valid=0 -> sdata=0, svalid=0, sid=0, busy=0 and req_ready=0 on every cycle.
- Single word, defaults: req_valid[2]=1 with word 0xA5 -> req_ready=4'b0100 for one cycle. The next 8 cycles show sdata=1,0,1,0,0,1,0,1 with svalid=1 and sid=2. Then 1 GAP cycle with busy=1 and svalid=0, then IDLE.
- Round robin: all four requesters valid continuously with words 0x11,0x22,0x33,0x44 -> grant order 0,1,2,3,0. Transfer edges are spaced 10 cycles apart, and the serial stream matches each word MSB-first with the matching sid.
- Zero gap: GAP_CYCLES=0 with requesters 1 and 3 valid -> words from 1 and 3 alternate. Exactly one svalid=0 cycle (IDLE) separates them, giving a 9-cycle period.
- Late requester: req_valid[0] rises at cycle 3 of a SHIFT serving requester 1 -> req_ready[0] stays 0 until IDLE. Requester 0 is granted ahead of requester 1, whose valid is still high.
- Reset mid-word: assert rst during bit 4 of word 0xFF from requester 3 -> outputs go to 0 asynchronously. After release, requester 0 is served first (last_grant restored to 3) and no remainder of 0xFF appears.
